pwm_multi_gen: RTL

Parametrised multi-channel PWM generator, successor to the single-channel duty-adjustable clock generator. Each channel's duty is stepped up and down by active-low push-button inputs. Duty changes are double-buffered and take effect only at period boundaries, so no output ever glitches. A build-time mode selects edge-aligned or centre-aligned PWM. All channels share one period counter and one `period_start` strobe for downstream sampling logic.

---
 rtl/pwm_multi_gen.sv | 115 +++++++++++
 1 files changed

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator with per-channel push-button duty control.
// Duty changes are shadowed and applied at period boundaries; edge- or centre-aligned by build.
module pwm_multi_gen #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned PERIOD    = 200,
    parameter int unsigned STEP      = 10,
    parameter int unsigned INIT_DUTY = 100,
    parameter int unsigned CENTER    = 0
) (
    input  logic                      clkin,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       inc,
    input  logic [CHANNELS-1:0]       dec,
    output logic [CHANNELS-1:0]       pwm,
    output logic [CHANNELS*WIDTH-1:0] d,
    output logic                      period_start
);

    localparam logic [WIDTH-1:0] CNT_TOP  = WIDTH'(PERIOD - 1);
    localparam logic [WIDTH-1:0] CNT_TURN = WIDTH'(PERIOD - 2);
    localparam logic [WIDTH:0]   PER_X    = (WIDTH+1)'(PERIOD);
    localparam logic [WIDTH:0]   STEP_X   = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] INIT     = WIDTH'(INIT_DUTY);

    logic [WIDTH-1:0]    cnt;
    logic [WIDTH-1:0]    cnt_nxt;
    logic                dir_up;
    logic                dir_nxt;
    logic                wrap_c;

    logic [CHANNELS-1:0] inc_s1, inc_s2, inc_p;
    logic [CHANNELS-1:0] dec_s1, dec_s2, dec_p;
    logic [CHANNELS-1:0] ev_inc_c, ev_dec_c;

    logic [WIDTH-1:0]    target     [CHANNELS];
    logic [WIDTH-1:0]    target_nxt [CHANNELS];

    // Falling edge of the synchronized button level: one event per press.
    assign ev_inc_c = inc_p & ~inc_s2;
    assign ev_dec_c = dec_p & ~dec_s2;

    // Shared period counter; wrap_c marks the edge where cnt returns to 0.
    always_comb begin
        cnt_nxt = cnt + WIDTH'(1);
        dir_nxt = dir_up;
        if (CENTER == 0) begin
            if (cnt == CNT_TOP) cnt_nxt = '0;
            dir_nxt = 1'b1;
        end else begin
            if (dir_up) begin
                if (cnt == CNT_TOP) begin
                    cnt_nxt = CNT_TURN;
                    dir_nxt = 1'b0;
                end
            end else begin
                cnt_nxt = cnt - WIDTH'(1);
            end
            if (cnt_nxt == '0) dir_nxt = 1'b1;
        end
        wrap_c = (cnt_nxt == '0);
    end

    // Saturating shadow duty update, evaluated one bit wider than the duty.
    always_comb begin
        for (int i = 0; i < int'(CHANNELS); i++) begin
            target_nxt[i] = target[i];
            if (ev_inc_c[i] && !ev_dec_c[i]) begin
                if (({1'b0, target[i]} + STEP_X) > PER_X)
                    target_nxt[i] = WIDTH'(PER_X);
                else
                    target_nxt[i] = WIDTH'({1'b0, target[i]} + STEP_X);
            end else if (ev_dec_c[i] && !ev_inc_c[i]) begin
                if ({1'b0, target[i]} < STEP_X)
                    target_nxt[i] = '0;
                else
                    target_nxt[i] = WIDTH'({1'b0, target[i]} - STEP_X);
            end
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            cnt          <= '0;
            dir_up       <= 1'b1;
            pwm          <= '0;
            period_start <= 1'b0;
            inc_s1       <= '1;
            inc_s2       <= '1;
            inc_p        <= '1;
            dec_s1       <= '1;
            dec_s2       <= '1;
            dec_p        <= '1;
            d            <= {CHANNELS{INIT}};
            for (int i = 0; i < int'(CHANNELS); i++) target[i] <= INIT;
        end else begin
            cnt          <= cnt_nxt;
            dir_up       <= dir_nxt;
            period_start <= (cnt == '0);
            // Buttons are asynchronous: two-flop synchronizer, then edge history.
            inc_s1       <= inc;
            inc_s2       <= inc_s1;
            inc_p        <= inc_s2;
            dec_s1       <= dec;
            dec_s2       <= dec_s1;
            dec_p        <= dec_s2;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                target[i] <= target_nxt[i];
                pwm[i]    <= (cnt < d[i*WIDTH +: WIDTH]);
                if (wrap_c) d[i*WIDTH +: WIDTH] <= target[i];
            end
        end
    end

endmodule
